spm_sequencer: RTL and testbench

- Operand/product sequencer for the serial/parallel multiplier `spm`.
- Accepts a parallel multiplicand/multiplier pair over a valid/ready handshake.
- Feeds the multiplicand to `spm` bit-serially (LSB first, then zero-padded) and holds the multiplier on `spm.a`.
- Deserializes the bit-serial `spm.y` stream back into a parallel 2*BITS product, returned over a second valid/ready handshake.

---
 rtl/spm_sequencer_if.sv | 23 ++
 rtl/spm_sequencer.sv | 120 ++++++++++++
 tb/tb_spm_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spm_sequencer_if.sv
// spm_sequencer_if: operand and product handshakes of the spm operand/product sequencer.
// master: operand producer / product consumer. slave: the sequencer.
interface spm_sequencer_if #(
  parameter int unsigned BITS = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [BITS-1:0]   in_x;
  logic [BITS-1:0]   in_a;
  logic              out_valid;
  logic              out_ready;
  logic [2*BITS-1:0] out_p;

  modport master (
    output in_valid, in_x, in_a, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_x, in_a, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/spm_sequencer.sv
// spm_sequencer: feeds a parallel operand pair to the serial/parallel multiplier spm
// (multiplicand bit-serial, LSB first, zero padded; multiplier held on spm_a) and
// deserializes the serial product back into a parallel 2*BITS result.
// Optional: define SPM_SEQ_PERF_EN to add the op_count and busy status outputs.
module spm_sequencer #(
  parameter int unsigned BITS = 32,
  parameter int unsigned LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  spm_sequencer_if.slave  bus,
  output logic            spm_rst,
  output logic            spm_x,
  output logic [BITS-1:0] spm_a,
  input  logic            spm_y
`ifdef SPM_SEQ_PERF_EN
  ,
  output logic [31:0]     op_count,
  output logic            busy
`endif
);

  localparam int unsigned CW = $clog2(2*BITS+LAT+1);
  localparam logic [CW-1:0] LAST = CW'(2*BITS+LAT-1);
  localparam logic [CW-1:0] LATC = CW'(LAT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [BITS-1:0]   xsr;
  logic [2*BITS-1:0] prod;
  logic              accept, last, hs;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode and transfer events
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    hs         = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.in_valid;
        if (accept) state_next = RUN;
      end
      RUN: begin
        last = (cnt == LAST);
        if (last) state_next = DONE;
      end
      DONE: begin
        hs = bus.out_ready;
        if (hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready = (state == IDLE);

  // Operand load, serial feed to spm and product deserialization.
  // spm_x is registered, so the shifter is loaded with in_x>>1 while bit 0 goes
  // straight to spm_x; each RUN edge then presents the next bit one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      xsr           <= '0;
      prod          <= '0;
      spm_rst       <= 1'b0;
      spm_x         <= 1'b0;
      spm_a         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            xsr     <= bus.in_x >> 1;
            spm_x   <= bus.in_x[0];
            spm_a   <= bus.in_a;
            prod    <= '0;
            cnt     <= '0;
            spm_rst <= 1'b1;
          end
        end
        RUN: begin
          cnt   <= cnt + CW'(1);
          xsr   <= xsr >> 1;
          spm_x <= last ? 1'b0 : xsr[0];
          if (cnt >= LATC) prod <= {spm_y, prod[2*BITS-1:1]};
          if (last) begin
            bus.out_p     <= {spm_y, prod[2*BITS-1:1]};
            bus.out_valid <= 1'b1;
            spm_rst       <= 1'b0;
          end
        end
        DONE: begin
          if (hs) bus.out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SPM_SEQ_PERF_EN
  // Completed-product counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    op_count <= '0;
    else if (hs) op_count <= op_count + 32'd1;
  end

  assign busy = (state != IDLE);
`endif

endmodule

// File: tb/tb_spm_sequencer.sv
// tb_spm_sequencer: directed checks of spm_sequencer at BITS=4 and BITS=32, each
// attached to a behavioural serial/parallel multiplier with one cycle of latency.
module tb_spm_sequencer;

  logic clk;
  logic rst;
  int unsigned nvec;
  int unsigned nerr;
  int unsigned exp_ops4;
  int unsigned exp_ops32;

  spm_sequencer_if #(.BITS(4))  b4 ();
  spm_sequencer_if #(.BITS(32)) b32 ();

  logic        sr4, sx4, sy4;
  logic [3:0]  sa4;
  logic        sr32, sx32, sy32;
  logic [31:0] sa32;

`ifdef SPM_SEQ_PERF_EN
  logic [31:0] oc4, oc32;
  logic        busy4, busy32;
`endif

  spm_sequencer #(.BITS(4), .LAT(1)) u4 (
    .clk(clk), .rst(rst), .bus(b4),
    .spm_rst(sr4), .spm_x(sx4), .spm_a(sa4), .spm_y(sy4)
`ifdef SPM_SEQ_PERF_EN
    , .op_count(oc4), .busy(busy4)
`endif
  );

  spm_sequencer #(.BITS(32), .LAT(1)) u32 (
    .clk(clk), .rst(rst), .bus(b32),
    .spm_rst(sr32), .spm_x(sx32), .spm_a(sa32), .spm_y(sy32)
`ifdef SPM_SEQ_PERF_EN
    , .op_count(oc32), .busy(busy32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural spm: add a when x=1, emit the LSB, keep the rest as carry-save partial
  logic [3:0]  p4;
  logic [4:0]  s4;
  logic [31:0] p32;
  logic [32:0] s32;
  assign s4  = {1'b0, p4}  + (sx4  ? {1'b0, sa4}  : 5'd0);
  assign s32 = {1'b0, p32} + (sx32 ? {1'b0, sa32} : 33'd0);

  always @(posedge clk or negedge sr4) begin
    if (!sr4) begin p4 <= '0; sy4 <= 1'b0; end
    else      begin p4 <= s4[4:1]; sy4 <= s4[0]; end
  end

  always @(posedge clk or negedge sr32) begin
    if (!sr32) begin p32 <= '0; sy32 <= 1'b0; end
    else       begin p32 <= s32[32:1]; sy32 <= s32[0]; end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One BITS=4 operation with out_ready held high; called right after a negedge
  task automatic op4(input logic [3:0] x, input logic [3:0] a, input logic [7:0] exp,
                     input string tag);
    int unsigned n;
    logic rdy_ok;
    logic busy_ok;
    chk({tag, "/ready_idle"}, b4.in_ready, 1);
    b4.in_valid = 1'b1; b4.in_x = x; b4.in_a = a; b4.out_ready = 1'b1;
    @(negedge clk);
    n = 0; rdy_ok = 1'b1; busy_ok = 1'b1;
    while (!b4.out_valid && n < 100) begin
      if (b4.in_ready !== 1'b0) rdy_ok = 1'b0;
`ifdef SPM_SEQ_PERF_EN
      if (busy4 !== 1'b1) busy_ok = 1'b0;
`endif
      b4.in_valid = 1'($urandom_range(0, 1));
      b4.in_x = 4'($urandom); b4.in_a = 4'($urandom);
      @(negedge clk);
      n++;
    end
    b4.in_valid = 1'b0;
    chk({tag, "/latency"}, n, 9);
    chk({tag, "/ready_run"}, rdy_ok, 1);
    chk({tag, "/busy_run"}, busy_ok, 1);
    chk({tag, "/ready_done"}, b4.in_ready, 0);
    chk({tag, "/out_p"}, b4.out_p, exp);
    @(negedge clk);
    exp_ops4++;
    chk({tag, "/valid_after_hs"}, b4.out_valid, 0);
    chk({tag, "/ready_after_hs"}, b4.in_ready, 1);
`ifdef SPM_SEQ_PERF_EN
    chk({tag, "/busy_after_hs"}, busy4, 0);
    chk({tag, "/op_count"}, oc4, exp_ops4);
`endif
  endtask

  // One BITS=32 operation with out_ready held high; called right after a negedge
  task automatic op32(input logic [31:0] x, input logic [31:0] a, input logic [63:0] exp,
                      input string tag);
    int unsigned n;
    chk({tag, "/ready_idle"}, b32.in_ready, 1);
    b32.in_valid = 1'b1; b32.in_x = x; b32.in_a = a; b32.out_ready = 1'b1;
    @(negedge clk);
    b32.in_valid = 1'b0; b32.in_x = $urandom; b32.in_a = $urandom;
    n = 0;
    while (!b32.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, n, 65);
    chk({tag, "/out_p"}, b32.out_p, exp);
    @(negedge clk);
    exp_ops32++;
    chk({tag, "/ready_after_hs"}, b32.in_ready, 1);
`ifdef SPM_SEQ_PERF_EN
    chk({tag, "/op_count"}, oc32, exp_ops32);
`endif
  endtask

  initial begin
    int unsigned n;
    logic stable;
    logic [31:0] rx, ra;
    nvec = 0; nerr = 0; exp_ops4 = 0; exp_ops32 = 0;
    rst = 1'b0;
    b4.in_valid = 1'b0;  b4.in_x = '0;  b4.in_a = '0;  b4.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_x = '0; b32.in_a = '0; b32.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst/in_ready", b4.in_ready, 1);
    chk("rst/out_valid", b4.out_valid, 0);
    chk("rst/out_p", b4.out_p, 0);
    chk("rst/spm_rst", sr4, 0);
    chk("rst/spm_x", sx4, 0);
    chk("rst/spm_a", sa4, 0);
    chk("rst/in_ready32", b32.in_ready, 1);
`ifdef SPM_SEQ_PERF_EN
    chk("rst/op_count", oc4, 0);
    chk("rst/busy", busy4, 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // BITS=4 directed products
    op4(4'd3, 4'd5, 8'd15, "3x5");
    op4(4'hF, 4'hF, 8'hE1, "FxF");
    op4(4'h0, 4'hF, 8'h00, "0xF");
    op4(4'hF, 4'h1, 8'h0F, "Fx1");
    op4(4'h8, 4'h8, 8'h40, "8x8");
    op4(4'hA, 4'h0, 8'h00, "Ax0");

    // Backpressure: product held for 20 cycles, new operands refused
    b4.in_valid = 1'b1; b4.in_x = 4'd6; b4.in_a = 4'd7; b4.out_ready = 1'b0;
    @(negedge clk);
    b4.in_valid = 1'b0;
    n = 0;
    while (!b4.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp/latency", n, 9);
    chk("bp/out_p", b4.out_p, 8'h2A);
    stable = 1'b1;
    repeat (20) begin
      b4.in_valid = 1'b1; b4.in_x = 4'($urandom); b4.in_a = 4'($urandom);
      @(negedge clk);
      if (b4.out_valid !== 1'b1 || b4.out_p !== 8'h2A || b4.in_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp/stable", stable, 1);
    b4.in_valid = 1'b0; b4.out_ready = 1'b1;
    @(negedge clk);
    exp_ops4++;
    chk("bp/valid_after_hs", b4.out_valid, 0);
    chk("bp/ready_after_hs", b4.in_ready, 1);
    @(negedge clk);
    chk("bp/no_stray_accept", b4.in_ready, 1);
`ifdef SPM_SEQ_PERF_EN
    chk("bp/op_count", oc4, exp_ops4);
`endif

    // Reset in RUN cycle 5 discards the operation
    b4.in_valid = 1'b1; b4.in_x = 4'd5; b4.in_a = 4'd5;
    @(negedge clk);
    b4.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst/ready_before", b4.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("midrst/out_valid", b4.out_valid, 0);
    chk("midrst/spm_rst", sr4, 0);
    chk("midrst/in_ready", b4.in_ready, 1);
    chk("midrst/out_p", b4.out_p, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_ops4 = 0;
    exp_ops32 = 0;
    @(negedge clk);
    op4(4'd7, 4'd9, 8'd63, "7x9");
    op4(4'd2, 4'd3, 8'd6, "2x3");

    // BITS=32 directed and reference-multiply products
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "w32/ones");
    op32(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "w32/2^16sq");
    op32(32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, "w32/onesx1");
    op32(32'h0000_0000, 32'hDEAD_BEEF, 64'h0, "w32/zero");
    op32(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, "w32/msb");
    for (int i = 0; i < 20; i++) begin
      rx = $urandom; ra = $urandom;
      op32(rx, ra, {32'b0, rx} * {32'b0, ra}, "w32/rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
